// File: rtl/gate_enable_gen_pkg.sv
// ----------------------------------------------------------------------------
// gate_enable_gen_pkg
// Shared definitions for the gate enable generator.
//   GateWidthDefault : default bit width of the length / count fields
//   gate_state_e     : FSM state encoding (IDLE=0, ON=1, OFF=2, DONE=3)
// ----------------------------------------------------------------------------
package gate_enable_gen_pkg;

   localparam int unsigned GateWidthDefault = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOn   = 2'd1,
      StOff  = 2'd2,
      StDone = 2'd3
   } gate_state_e;

endpackage : gate_enable_gen_pkg

// File: rtl/gate_enable_gen.sv
// ----------------------------------------------------------------------------
// gate_enable_gen
// Generates a burst of enable pulses for a downstream gate stage. Each pulse
// is high for on_len cycles, separated by off_len low cycles, repeated
// burst_count times. A one-cycle done pulse marks normal completion.
//
// Ports
//   i_clock       : single clock, all state updates on its rising edge
//   i_reset       : synchronous, active-high reset (highest priority)
//   i_start       : request a burst sequence, only sampled in IDLE
//   i_stop        : abort a running sequence (ON/OFF); beats start in IDLE
//   i_on_len      : cycles enable is high per pulse
//   i_off_len     : cycles enable is low between pulses
//   i_burst_count : number of enable pulses per sequence
//   o_enable      : registered enable, high only in ON
//   o_busy        : high in ON, OFF and DONE
//   o_done        : one-cycle pulse on normal completion
//   o_pulse_idx   : zero-based index of the current / last pulse
// ----------------------------------------------------------------------------
module gate_enable_gen
   import gate_enable_gen_pkg::*;
#(
   parameter int unsigned WIDTH = GateWidthDefault
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic [WIDTH-1:0] i_on_len,
   input  logic [WIDTH-1:0] i_off_len,
   input  logic [WIDTH-1:0] i_burst_count,
   output logic             o_enable,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_pulse_idx
);

   gate_state_e      r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_on_len;
   logic [WIDTH-1:0] r_off_len;
   logic [WIDTH-1:0] r_burst_count;
   logic [WIDTH-1:0] r_pulse_idx;
   logic             r_enable;
   logic             r_busy;
   logic             r_done;

   // Index of the final pulse; only meaningful while running, where the
   // latched burst count is known to be nonzero.
   logic [WIDTH-1:0] w_last_idx;
   logic             w_last_pulse;
   logic             w_cnt_zero;

   assign w_last_idx   = r_burst_count - 1'b1;
   assign w_last_pulse = (r_pulse_idx == w_last_idx);
   assign w_cnt_zero   = (r_cnt == '0);

   // Outputs are registered alongside the state so that each output is a
   // flop, not a decode of the state bits.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_on_len      <= '0;
         r_off_len     <= '0;
         r_burst_count <= '0;
         r_pulse_idx   <= '0;
         r_enable      <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               r_enable <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               if (i_start && !i_stop) begin
                  r_on_len      <= i_on_len;
                  r_off_len     <= i_off_len;
                  r_burst_count <= i_burst_count;
                  r_pulse_idx   <= '0;
                  r_busy        <= 1'b1;
                  // Degenerate request: nothing to emit, report completion.
                  if ((i_on_len == '0) || (i_burst_count == '0)) begin
                     r_state <= StDone;
                     r_cnt   <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= StOn;
                     r_cnt    <= i_on_len - 1'b1;
                     r_enable <= 1'b1;
                  end
               end
            end

            StOn: begin
               if (i_stop) begin
                  r_state  <= StIdle;
                  r_cnt    <= '0;
                  r_enable <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b0;
               end else if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (w_last_pulse) begin
                  // Last pulse ends straight into DONE, no trailing gap.
                  r_state  <= StDone;
                  r_enable <= 1'b0;
                  r_done   <= 1'b1;
               end else if (r_off_len == '0) begin
                  // Zero gap: back-to-back pulses, enable stays high.
                  r_state     <= StOn;
                  r_cnt       <= r_on_len - 1'b1;
                  r_pulse_idx <= r_pulse_idx + 1'b1;
               end else begin
                  r_state  <= StOff;
                  r_cnt    <= r_off_len - 1'b1;
                  r_enable <= 1'b0;
               end
            end

            StOff: begin
               if (i_stop) begin
                  r_state  <= StIdle;
                  r_cnt    <= '0;
                  r_enable <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b0;
               end else if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_state     <= StOn;
                  r_cnt       <= r_on_len - 1'b1;
                  r_pulse_idx <= r_pulse_idx + 1'b1;
                  r_enable    <= 1'b1;
               end
            end

            StDone: begin
               // Stop is irrelevant here: the done pulse is already out.
               r_state  <= StIdle;
               r_cnt    <= '0;
               r_enable <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end

            default: begin
               r_state  <= StIdle;
               r_cnt    <= '0;
               r_enable <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   assign o_enable    = r_enable;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pulse_idx = r_pulse_idx;

endmodule : gate_enable_gen

// File: tb/tb_gate_enable_gen.sv
// ----------------------------------------------------------------------------
// tb_gate_enable_gen
// Directed, table-driven bench for gate_enable_gen. Each table row holds the
// inputs applied during one cycle and the outputs expected after the next
// rising edge.
// ----------------------------------------------------------------------------
module tb_gate_enable_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [7:0] on_len;
   logic [7:0] off_len;
   logic [7:0] burst;
   logic       en;
   logic       busy;
   logic       done;
   logic [7:0] idx;

   int n_cmp;
   int n_err;

   typedef struct {
      logic       rst;
      logic       start;
      logic       stop;
      logic [7:0] on_len;
      logic [7:0] off_len;
      logic [7:0] burst;
      logic       en;
      logic       busy;
      logic       done;
      logic [7:0] idx;
   } vec_t;

   vec_t tbl[$];

   gate_enable_gen #(
      .WIDTH(8)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_stop       (stop),
      .i_on_len     (on_len),
      .i_off_len    (off_len),
      .i_burst_count(burst),
      .o_enable     (en),
      .o_busy       (busy),
      .o_done       (done),
      .o_pulse_idx  (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input logic r, input logic st, input logic sp,
                              input logic [7:0] onl, input logic [7:0] offl,
                              input logic [7:0] b, input logic e, input logic bz,
                              input logic d, input logic [7:0] ix);
      vec_t t;
      t.rst     = r;
      t.start   = st;
      t.stop    = sp;
      t.on_len  = onl;
      t.off_len = offl;
      t.burst   = b;
      t.en      = e;
      t.busy    = bz;
      t.done    = d;
      t.idx     = ix;
      return t;
   endfunction

   // Idle inputs with an expected output set.
   function automatic vec_t w(input logic e, input logic bz, input logic d,
                              input logic [7:0] ix);
      return v(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, e, bz, d, ix);
   endfunction

   task automatic chk(input string name, input int row, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   int  en_cycles;
   int  done_seen;
   logic en_at_done;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst     = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      on_len  = 8'd0;
      off_len = 8'd0;
      burst   = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_enable", -1, {7'd0, en}, 8'd0);
      chk("reset_busy", -1, {7'd0, busy}, 8'd0);
      chk("reset_done", -1, {7'd0, done}, 8'd0);
      chk("reset_idx", -1, idx, 8'd0);

      // 3/2/2: enable cycles 1-3 and 6-8, done at 9; inputs cleared after latch
      tbl.push_back(v(0, 1, 0, 8'd3, 8'd2, 8'd2, 1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(0, 1, 0, 8'd0));
      tbl.push_back(w(0, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd1));
      tbl.push_back(w(1, 1, 0, 8'd1));
      tbl.push_back(w(1, 1, 0, 8'd1));
      tbl.push_back(w(0, 1, 1, 8'd1));
      tbl.push_back(w(0, 0, 0, 8'd1));
      // reset in idle clears the retained pulse index
      tbl.push_back(v(1, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0, 8'd0));
      // 2/0/3: continuous enable cycles 1-6, done at 7
      tbl.push_back(v(0, 1, 0, 8'd2, 8'd0, 8'd3, 1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd1));
      tbl.push_back(w(1, 1, 0, 8'd1));
      tbl.push_back(w(1, 1, 0, 8'd2));
      tbl.push_back(w(1, 1, 0, 8'd2));
      tbl.push_back(w(0, 1, 1, 8'd2));
      tbl.push_back(w(0, 0, 0, 8'd2));
      // start together with stop in idle: nothing happens, index retained
      tbl.push_back(v(0, 1, 1, 8'd3, 8'd1, 8'd2, 0, 0, 0, 8'd2));
      tbl.push_back(w(0, 0, 0, 8'd2));
      // on_len=0: immediate done, busy only for that cycle
      tbl.push_back(v(0, 1, 0, 8'd0, 8'd4, 8'd5, 0, 1, 1, 8'd0));
      tbl.push_back(w(0, 0, 0, 8'd0));
      // burst_count=0: immediate done
      tbl.push_back(v(0, 1, 0, 8'd3, 8'd1, 8'd0, 0, 1, 1, 8'd0));
      tbl.push_back(w(0, 0, 0, 8'd0));
      // start re-pulsed with new lengths while running: ignored
      tbl.push_back(v(0, 1, 0, 8'd2, 8'd1, 8'd2, 1, 1, 0, 8'd0));
      tbl.push_back(v(0, 1, 0, 8'd7, 8'd7, 8'd7, 1, 1, 0, 8'd0));
      tbl.push_back(v(0, 1, 0, 8'd7, 8'd7, 8'd7, 0, 1, 0, 8'd0));
      tbl.push_back(v(0, 0, 0, 8'd7, 8'd7, 8'd7, 1, 1, 0, 8'd1));
      tbl.push_back(v(0, 0, 0, 8'd7, 8'd7, 8'd7, 1, 1, 0, 8'd1));
      tbl.push_back(v(0, 0, 0, 8'd7, 8'd7, 8'd7, 0, 1, 1, 8'd1));
      tbl.push_back(v(0, 1, 0, 8'd7, 8'd7, 8'd7, 0, 0, 0, 8'd1));
      tbl.push_back(w(0, 0, 0, 8'd1));
      // stop during ON (4/1/2, stop at cycle 2)
      tbl.push_back(v(0, 1, 0, 8'd4, 8'd1, 8'd2, 1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(v(0, 0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 0, 8'd0));
      tbl.push_back(w(0, 0, 0, 8'd0));
      // stop during OFF
      tbl.push_back(v(0, 1, 0, 8'd1, 8'd3, 8'd2, 1, 1, 0, 8'd0));
      tbl.push_back(w(0, 1, 0, 8'd0));
      tbl.push_back(v(0, 0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 0, 8'd0));
      tbl.push_back(w(0, 0, 0, 8'd0));
      // stop while in DONE: done still pulses
      tbl.push_back(v(0, 1, 0, 8'd1, 8'd0, 8'd1, 1, 1, 0, 8'd0));
      tbl.push_back(w(0, 1, 1, 8'd0));
      tbl.push_back(v(0, 0, 1, 8'd0, 8'd0, 8'd0, 0, 0, 0, 8'd0));
      // reset mid-sequence wins over start, then a normal 5-cycle pulse
      tbl.push_back(v(0, 1, 0, 8'd1, 8'd0, 8'd3, 1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd1));
      tbl.push_back(v(1, 1, 0, 8'd5, 8'd1, 8'd1, 0, 0, 0, 8'd0));
      tbl.push_back(v(0, 1, 0, 8'd5, 8'd0, 8'd1, 1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(1, 1, 0, 8'd0));
      tbl.push_back(w(0, 1, 1, 8'd0));
      tbl.push_back(w(0, 0, 0, 8'd0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst     = tbl[i].rst;
         start   = tbl[i].start;
         stop    = tbl[i].stop;
         on_len  = tbl[i].on_len;
         off_len = tbl[i].off_len;
         burst   = tbl[i].burst;
         @(posedge clk);
         #1;
         chk("enable", i, {7'd0, en}, {7'd0, tbl[i].en});
         chk("busy", i, {7'd0, busy}, {7'd0, tbl[i].busy});
         chk("done", i, {7'd0, done}, {7'd0, tbl[i].done});
         chk("pulse_idx", i, idx, tbl[i].idx);
      end

      // Maximum length pulse: exactly 255 enable cycles, then done.
      rst        = 1'b0;
      start      = 1'b1;
      stop       = 1'b0;
      on_len     = 8'd255;
      off_len    = 8'd0;
      burst      = 8'd1;
      en_cycles  = 0;
      done_seen  = 0;
      en_at_done = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      on_len = 8'd0;
      burst  = 8'd0;
      for (int c = 0; c < 600; c++) begin
         if (done === 1'b1) begin
            done_seen  = 1;
            en_at_done = en;
            break;
         end
         if (en === 1'b1) en_cycles++;
         @(posedge clk);
         #1;
      end
      chk("maxlen_done_seen", 0, done_seen[7:0], 8'd1);
      chk("maxlen_enable_cycles", 0, en_cycles[7:0], 8'd255);
      chk("maxlen_enable_cycles_hi", 0, en_cycles[15:8], 8'd0);
      chk("maxlen_enable_at_done", 0, {7'd0, en_at_done}, 8'd0);
      @(posedge clk);
      #1;
      chk("maxlen_idle_busy", 0, {7'd0, busy}, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_gate_enable_gen

// File: doc/gate_enable_gen.md
GATE_ENABLE_GEN -- requirements
Module: gate_enable_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the length and count fields.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a burst sequence; sampled only in IDLE.
REQ-005 SHALL have port stop  input  1  abort the running sequence.
REQ-006 SHALL have port on_len  input  WIDTH  cycles enable is high per pulse.
REQ-007 SHALL have port off_len  input  WIDTH  cycles enable is low between pulses.
REQ-008 SHALL have port burst_count  input  WIDTH  number of enable pulses per sequence.
REQ-009 SHALL have port enable  output  1  registered enable driven to the downstream gate stage.
REQ-010 SHALL have port busy  output  1  high in ON, OFF and DONE states.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.
REQ-012 SHALL have port pulse_idx  output  WIDTH  zero-based index of the current/last pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ON, OFF, DONE; enable=1 only in ON.
REQ-014 SHALL, in IDLE with start=1 and stop=0, latch on_len, off_len, burst_count into internal registers and clear pulse_idx.
REQ-015 SHALL, with start sampled at cycle N and nonzero latched on_len and burst_count, drive enable high on cycles N+1 through N+on_len inclusive.
REQ-016 SHALL, when an ON period ends and it is not the last pulse, enter OFF for off_len cycles; if off_len=0, go directly to the next ON with no low cycle.
REQ-017 SHALL increment pulse_idx on each OFF->ON (or ON->ON) transition, with modulo-2^WIDTH wrap.
REQ-018 SHALL, when the last ON period ends, enter DONE with no trailing OFF period.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 SHALL, on start with latched on_len=0 or burst_count=0, go straight to DONE: done pulses at N+1, and enable never rises.
REQ-021 SHALL ignore start outside IDLE; input changes after latching SHALL NOT affect the running sequence.
REQ-022 SHALL, on stop=1 in ON or OFF, go to IDLE next cycle with enable=0 and no done pulse.
REQ-023 SHALL give stop priority over start when both are high in IDLE; the block stays in IDLE.
REQ-024 SHALL let stop=1 in DONE have no effect; done still pulses.
REQ-025 SHALL count in each state with a down-counter of WIDTH bits, loaded with (length-1) and terminating at 0, so lengths up to 2^WIDTH-1 are exact.

Reset
REQ-026 SHALL, with reset=1 at a posedge, force state IDLE, enable=0, busy=0, done=0, pulse_idx=0, and all counters and latched fields to 0.
REQ-027 SHALL, with reset asserted mid-sequence, drop enable on the next cycle with no done pulse.
REQ-028 SHALL give reset priority over start and stop.

Structure
REQ-029 SHALL place the state encoding (IDLE=0, ON=1, OFF=2, DONE=3) and the WIDTH default in a shared package.
REQ-030 SHALL be a single module with no sub-modules; its enable output connects directly to the gate stage enable input.

Verification
REQ-031 SHALL cover: on_len=3, off_len=2, burst_count=2, start at cycle 0 -> enable high on cycles 1-3 and 6-8, done at cycle 9, pulse_idx=1.
REQ-032 SHALL cover: on_len=2, off_len=0, burst_count=3 -> enable continuously high on cycles 1-6, done at cycle 7.
REQ-033 SHALL cover: on_len=0, burst_count=5 -> enable stays 0, done at cycle 1, busy high only on cycle 1.
REQ-034 SHALL cover: on_len=4, burst_count=2, stop at cycle 2 -> enable 0 from cycle 3, no done, busy 0 at cycle 3.
REQ-035 SHALL cover: start and stop together in IDLE -> no state change; start re-pulsed during ON -> sequence unchanged.
REQ-036 SHALL cover: reset asserted at cycle 2 of an on_len=5 pulse -> all outputs 0 at cycle 3; a new start afterwards runs a normal sequence.
